// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int ITER_W   = $clog2(MD_WIDTH) + 1;
    localparam logic [MD_WIDTH-1:0] MIN_INT = MD_WIDTH'(1) << (MD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/multdiv_ctrl.sv
// Sequencer for multdiv: operation state and iteration counter.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic start_mul,
    input  logic start_div,
    output logic busy,
    output logic is_mul,
    output logic is_div,
    output logic last_iter,
    output logic done
);

    state_t            state, state_next;
    logic [ITER_W-1:0] counter;

    assign is_mul    = (state == MUL);
    assign is_div    = (state == DIV);
    assign busy      = is_mul | is_div;
    assign done      = (state == DONE);
    assign last_iter = busy && (counter == ITER_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state <= state_next;
            if (start_mul || start_div) begin
                counter <= '0;
            end else if (busy) begin
                counter <= counter + ITER_W'(1);
            end
        end
    end

    // A start pulse overrides whatever is in flight, including DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            MUL:     if (last_iter) state_next = DONE;
            DIV:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (start_mul) begin
            state_next = MUL;
        end else if (start_div) begin
            state_next = DIV;
        end
    end

endmodule

// File: rtl/multdiv.sv
// Radix-2 signed multiply (Booth) / divide (non-restoring) unit, one bit per cycle.
module multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] data_operandA,
    input  logic signed [WIDTH-1:0] data_operandB,
    input  logic                    ctrl_MULT,
    input  logic                    ctrl_DIV,
    output logic        [WIDTH-1:0] data_result,
    output logic                    data_exception,
    output logic                    data_resultRDY
);

    logic start_mul, start_div, start_any;
    logic busy, is_mul, is_div, last_iter, done;

    assign start_mul = ctrl_MULT;
    assign start_div = ctrl_DIV & ~ctrl_MULT;
    assign start_any = ctrl_MULT | ctrl_DIV;

    multdiv_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .start_mul (start_mul),
        .start_div (start_div),
        .busy      (busy),
        .is_mul    (is_mul),
        .is_div    (is_div),
        .last_iter (last_iter),
        .done      (done)
    );

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (WIDTH'(0) - v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] mag, input logic neg);
        return neg ? (WIDTH'(0) - mag) : mag;
    endfunction

    function automatic logic mul_overflow(input logic [2*WIDTH-1:0] p);
        return p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
    endfunction

    // Operand / iteration registers (data only, no reset)
    logic signed [2*WIDTH:0]   prod_p;
    logic signed [WIDTH-1:0]   mcand_p;
    logic signed [WIDTH+1:0]   rem_p;
    logic        [WIDTH-1:0]   quo_p;
    logic        [WIDTH-1:0]   dvsr_p;
    logic                      neg_p, dzero_p, dovf_p;

    logic signed [WIDTH:0]     acc, mcand_ext, booth_sum;
    logic signed [2*WIDTH:0]   prod_next;
    logic signed [WIDTH+1:0]   rem_sh, dvsr_ext, rem_next;
    logic        [WIDTH-1:0]   quo_next;
    logic        [WIDTH-1:0]   mul_res, div_res;
    logic                      mul_exc, div_exc;

    // Booth step: the accumulator is one bit wider so a -MIN_INT partial sum keeps its sign.
    always_comb begin
        acc       = {prod_p[2*WIDTH], prod_p[2*WIDTH:WIDTH+1]};
        mcand_ext = {mcand_p[WIDTH-1], mcand_p};
        case (prod_p[1:0])
            2'b01:   booth_sum = acc + mcand_ext;
            2'b10:   booth_sum = acc - mcand_ext;
            default: booth_sum = acc;
        endcase
        prod_next = {booth_sum, prod_p[WIDTH:1]};
        mul_res   = prod_next[WIDTH:1];
        mul_exc   = mul_overflow(prod_next[2*WIDTH:1]);
    end

    // Non-restoring step on magnitudes; quotient bit is set when the new remainder is non-negative.
    always_comb begin
        rem_sh   = {rem_p[WIDTH:0], quo_p[WIDTH-1]};
        dvsr_ext = {2'b00, dvsr_p};
        rem_next = rem_p[WIDTH+1] ? (rem_sh + dvsr_ext) : (rem_sh - dvsr_ext);
        quo_next = {quo_p[WIDTH-2:0], ~rem_next[WIDTH+1]};
        div_res  = dzero_p ? '0 : fix_sign(quo_next, neg_p);
        div_exc  = dzero_p | dovf_p;
    end

    always_ff @(posedge clk) begin
        if (start_mul) begin
            prod_p  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            mcand_p <= data_operandA;
        end else if (start_div) begin
            rem_p   <= '0;
            quo_p   <= magnitude(data_operandA);
            dvsr_p  <= magnitude(data_operandB);
            neg_p   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dzero_p <= (data_operandB == '0);
            dovf_p  <= (data_operandA == WIDTH'(MIN_INT)) && (data_operandB == '1);
        end else if (busy && is_mul) begin
            prod_p <= prod_next;
        end else if (busy && is_div) begin
            rem_p <= rem_next;
            quo_p <= quo_next;
        end
    end

    // Result capture on entry to DONE; a restart in the final iteration leaves the old result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (last_iter && !start_any) begin
            if (is_mul) begin
                data_result    <= mul_res;
                data_exception <= mul_exc;
            end else if (is_div) begin
                data_result    <= div_res;
                data_exception <= div_exc;
            end
        end
    end

    assign data_resultRDY = done;

endmodule

// File: tb/tb_multdiv.sv
// Directed scoreboard bench for multdiv: result, exception and RDY timing.
module tb_multdiv;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    multdiv #(.WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   rdy_count = 0;
    int   base;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Every RDY pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (data_resultRDY !== 1'b0) begin
            rdy_count++;
            if (sb.size() == 0) begin
                check("unexpected_rdy", {63'd0, data_resultRDY}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rdy_cycle", 64'(cyc), 64'(e.cyc));
                check("result", {32'd0, data_result}, {32'd0, e.res});
                check("exception", {63'd0, data_exception}, {63'd0, e.exc});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input logic mul, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic exc);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mul;
        ctrl_DIV      = ~mul;
        sb.push_back('{res: res, exc: exc, cyc: cyc + 33});
        tick(1);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 80 && sb.size() != 0; i++) tick(1);
        check({tag, "_drain"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        tick(2);
        check("reset_result", {32'd0, data_result}, 64'd0);
        check("reset_exception", {63'd0, data_exception}, 64'd0);
        check("reset_rdy", {63'd0, data_resultRDY}, 64'd0);
        reset = 1'b1;
        tick(1);

        go(1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        drain("mul_7x-3");
        go(1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        drain("mul_ovf");
        go(1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
        drain("mul_minx1");
        go(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        drain("mul_minx-1");

        go(1'b0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
        drain("div_-100/7");
        go(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        drain("div_min/-1");
        go(1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        drain("div_7/-2");

        go(1'b0, 32'd5, 32'd0, 32'd0, 1'b1);
        drain("div_by_zero");
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("hold_result", {32'd0, data_result}, 64'd0);
            check("hold_exception", {63'd0, data_exception}, 64'd1);
        end

        base = rdy_count;
        go(1'b1, 32'd3, 32'd4, 32'd12, 1'b0);
        tick(4);
        sb.delete(sb.size() - 1);
        go(1'b0, 32'd20, 32'd4, 32'd5, 1'b0);
        tick(50);
        check("restart_rdy_count", 64'(rdy_count - base), 64'd1);
        check("restart_drain", 64'(sb.size()), 64'd0);

        base = rdy_count;
        go(1'b1, 32'd2, 32'd3, 32'd6, 1'b0);
        tick(32);
        go(1'b1, 32'd4, 32'd5, 32'd20, 1'b0);
        drain("coincident");
        check("coincident_rdy_count", 64'(rdy_count - base), 64'd2);

        go(1'b0, 32'd100, 32'd10, 32'd10, 1'b0);
        tick(9);
        sb.delete(sb.size() - 1);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("midreset_result", {32'd0, data_result}, 64'd0);
        check("midreset_exception", {63'd0, data_exception}, 64'd0);
        check("midreset_rdy", {63'd0, data_resultRDY}, 64'd0);
        base = rdy_count;
        tick(40);
        check("midreset_no_rdy", 64'(rdy_count - base), 64'd0);
        go(1'b1, 32'd6, 32'd7, 32'd42, 1'b0);
        drain("mul_6x7");

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv.md
Name: multdiv

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage of the processor.
- Its result and exception flag are written directly into the 32-bit register-file write port and the status register. Those are enable-gated flip-flop registers, so a single-cycle ready pulse drives their write_enable.
- Radix-2, one bit per cycle. Only one operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset: low at a rising clk edge resets the block. One clock; no other clock or reset domain.
- data_operandA  input  WIDTH  multiplicand / dividend, two's complement; sampled only in the cycle ctrl_MULT or ctrl_DIV is high.
- data_operandB  input  WIDTH  multiplier / divisor, two's complement; sampled with operandA.
- ctrl_MULT  input  1  single-cycle start pulse for multiply.
- ctrl_DIV  input  1  single-cycle start pulse for divide.
- data_result  output  WIDTH  low WIDTH bits of product, or quotient.
- data_exception  output  1  overflow / divide-by-zero flag, valid with result.
- data_resultRDY  output  1  one-cycle pulse marking result and exception valid; connects to the destination register's write_enable.

Behaviour:
- Reset (reset low at an edge) clears the following regardless of state:
  - state=IDLE, counter=0;
  - data_result=0, data_exception=0, data_resultRDY=0.
  - A reset mid-operation aborts it; no RDY pulse follows.
- States and transitions:
  - IDLE: waits for a start pulse.
  - MUL: Booth radix-2, 2*WIDTH+1-bit product register.
  - DIV: non-restoring division on magnitudes, sign fix-up at end.
  - DONE: drives RDY.
- Start: a start pulse seen at the edge ending cycle 0 latches the operands, clears the counter and enters MUL or DIV.
  - If ctrl_MULT and ctrl_DIV are both high, MULT wins.
- Iterations: one iteration per cycle in cycles 1..WIDTH, then DONE.
  - data_resultRDY is high in cycle WIDTH+1 (cycle 33 for the default), for exactly one cycle.
  - Next state after DONE is IDLE.
- Restart: a start pulse in any state, including MUL, DIV or DONE, aborts the current operation and restarts with the new operands.
  - No RDY is produced for the aborted operation.
  - Latency counts from the new pulse.
  - A pulse in the same cycle as RDY starts a new operation; the RDY of that cycle still occurs.
- Output holding: data_result and data_exception update only on entry to DONE and hold until the next DONE or reset. They are not cleared on start.
- Multiply:
  - data_result = product[WIDTH-1:0].
  - data_exception=1 iff the full 2*WIDTH-bit signed product differs from the sign extension of product[WIDTH-1:0].
- Divide:
  - Signed quotient, truncated toward zero; remainder discarded.
  - Divisor 0: result=0, exception=1, same latency.
  - Dividend = -2^(WIDTH-1) with divisor = -1: result=0x80000000, exception=1.
  - Otherwise exception=0.
- Operand inputs are don't-care outside start cycles.

Decomposition:
- Shared package holds:
  - state encodings: IDLE, MUL, DIV, DONE;
  - ITER_W = clog2(WIDTH)+1 counter width;
  - constant MIN_INT = 1<<(WIDTH-1).
- One sub-module, multdiv_ctrl, holds:
  - the FSM and iteration counter;
  - outputs: busy, is_mul, is_div, last_iter, done.
- Datapath (Booth and non-restoring steps, sign fix-up, exception logic) stays in multdiv.

Test Plan:
- Multiply: reset low 2 cycles, release; ctrl_MULT with A=7, B=-3 (0xFFFFFFFD) in cycle 0.
  - Expect RDY only in cycle 33, result=0xFFFFFFEB, exception=0.
- Multiply overflow: A=0x00010000, B=0x00010000.
  - Expect result=0x00000000, exception=1.
  - Then A=0x80000000, B=1 gives result=0x80000000, exception=0.
- Divide: A=-100, B=7 gives result=0xFFFFFFF2 (-14), exception=0.
  - A=0x80000000, B=-1 gives result=0x80000000, exception=1.
- Divide by zero: A=5, B=0.
  - Expect result=0, exception=1, RDY in cycle 33.
  - Result holds through 10 idle cycles.
- Restart: ctrl_MULT with 3*4 in cycle 0, then ctrl_DIV with 20/4 in cycle 5.
  - Expect exactly one RDY, in cycle 38, with result=5.
  - Also, a start pulse coincident with RDY yields a second RDY 33 cycles later.
- Reset mid-operation: ctrl_DIV 100/10, reset low in cycle 10.
  - Expect no RDY ever; result=0, exception=0 after the reset edge.
  - Next MULT 6*7 gives 42 in cycle 33 of the new operation.
